wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback arbiter feeding the register file write port (rd, datain, reg_write).
//   Merges ALU results (no backpressure) and load results (valid/ready) onto the single port.
//   Load results are buffered in a small FIFO.
//   Exports a pending-write mask so the hazard unit can stall consumers of in-flight loads.
// PARAMETERS
//   XLEN          32  data width of results and datain
//   DEPTH         2   load FIFO entries; power of 2, >=2
//   STARVE_LIMIT  4   consecutive ALU wins with non-empty FIFO before alu_hold asserts; 1..15
// PORTS
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-low reset
//   alu_valid  in   1     ALU result present this cycle
//   alu_rd     in   5     ALU destination register
//   alu_data   in   XLEN  ALU result
//   alu_hold   out  1     upstream must not assert alu_valid next cycle while high
//   ld_valid   in   1     load result offered
//   ld_ready   out  1     load result accepted when ld_valid && ld_ready
//   ld_rd      in   5     load destination register
//   ld_data    in   XLEN  load data
//   rd         out  5     register-file write address (registered)
//   datain     out  XLEN  register-file write data (registered)
//   reg_write  out  1     register-file write enable (registered)
//   pend_mask  out  32    bit r=1: a FIFO entry targets x r; bit 0 always 0
// BEHAVIOUR
//   - Reset (reset=0, async): FIFO pointers/count=0, starve_cnt=0.
//     reg_write=0, rd=0, datain=0, alu_hold=0, pend_mask=0. Buffered loads are discarded.
//   - ld_ready = (count < DEPTH); it depends only on registered state (no combinational path from pop).
//   - Source select each cycle, priority order:
//     1) alu_valid -> ALU.
//     2) FIFO non-empty -> FIFO head (pop).
//     3) Load handshake this cycle with FIFO empty -> bypass (load not enqueued).
//     4) none.
//   - An accepted load not bypassed is pushed. Push and pop in the same cycle are legal; count is unchanged.
//   - Output register at posedge:
//     - reg_write <= selected && sel_rd != 0.
//     - rd/datain <= selected rd/data when selected; otherwise hold the previous value.
//     - A write to x0 is consumed (popped/accepted) but reg_write stays 0.
//   - Latency:
//     - ALU: 1 cycle.
//     - Load with empty FIFO and no ALU: 1 cycle.
//     - Buffered load: pops in FIFO order, at the first cycle with no alu_valid (or under alu_hold).
//   - Starvation counter, starve_cnt (4 bits):
//     - +1 (saturating at STARVE_LIMIT) on each cycle where the ALU wins with the FIFO non-empty.
//     - Cleared on any FIFO pop, or when the FIFO is empty.
//     - alu_hold = (starve_cnt == STARVE_LIMIT).
//     - Upstream honouring hold leaves a cycle with no alu_valid, so the head drains.
//     - If alu_valid arrives despite hold, the ALU still wins and nothing is dropped; hold stays high.
//   - pend_mask is the OR of one-hot(rd) over valid FIFO entries with rd != 0.
//     - An entry's bit clears in the cycle after its pop, i.e. the same edge its reg_write asserts.
//     - Bypassed loads never set pend_mask.
//   - No ordering guarantee between ALU and load to the same rd.
//     The hazard unit must use pend_mask to prevent an ALU op targeting a pending rd.
//   - Full FIFO with ld_valid: ld_ready=0, no enqueue, and the load source must hold its data stable.
// TESTING
//   T1 ALU only: alu_valid, rd=5, data=0xDEADBEEF at cycle 0.
//      -> cycle 1: reg_write=1, rd=5, datain=0xDEADBEEF.
//   T2 Bypass: FIFO empty, ld_valid, rd=7, data=0x12, no ALU.
//      -> ld_ready=1, next cycle reg_write=1, rd=7; pend_mask stays 0.
//   T3 Collision: alu rd=3 and ld rd=4 in the same cycle.
//      -> ALU written first, pend_mask[4]=1.
//      -> next idle cycle writes rd=4; pend_mask[4] clears on that edge.
//   T4 Full: hold alu_valid, offer 3 loads.
//      -> 2 accepted (ld_ready=1,1,0), FIFO order preserved on drain.
//   T5 Starvation: FIFO non-empty, alu_valid for 4 cycles.
//      -> alu_hold=1 after the 4th; drop alu_valid one cycle -> head pops, alu_hold=0.
//   T6 x0 and reset: load rd=0 -> accepted, reg_write stays 0.
//      -> reset=0 mid-drain clears outputs immediately, and ld_ready=1 after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Purpose : bundles the writeback arbiter's source and sink signals.
// Signals :
//   alu_valid/alu_rd/alu_data  ALU result (no backpressure)
//   alu_hold                   asks the ALU side to skip the next cycle
//   ld_valid/ld_rd/ld_data     load result offered (valid/ready)
//   ld_ready                   load accepted when ld_valid && ld_ready
//   rd/datain/reg_write        register-file write port (registered)
//   pend_mask                  destinations of loads still buffered
// Modports: master = producers/consumers around the arbiter,
//           slave  = the arbiter itself.
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_hold;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  logic [4:0]      rd;
  logic [XLEN-1:0] datain;
  logic            reg_write;
  logic [31:0]     pend_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_hold, ld_ready, rd, datain, reg_write, pend_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_hold, ld_ready, rd, datain, reg_write, pend_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Purpose : merges ALU results and load results onto the single register-file
//           write port. Loads that lose arbitration wait in a small FIFO; a
//           pending-write mask lets the hazard unit stall on buffered loads.
//           A starvation counter raises alu_hold so buffered loads drain.
// Ports   :
//   i_clk    rising-edge clock
//   i_reset  asynchronous, active-low reset
//   io_bus   wb_arbiter_if.slave (ALU in, load in, write port out, pend_mask)
// Parameters:
//   XLEN          data width
//   DEPTH         load FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT  consecutive ALU wins over a non-empty FIFO before alu_hold
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  wb_arbiter_if.slave  io_bus
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO,
    SEL_BYPASS
  } sel_e;

  logic [4:0]      r_fifoRd   [DEPTH];
  logic [XLEN-1:0] r_fifoData [DEPTH];
  logic [PTRW-1:0] r_wrPtr;
  logic [PTRW-1:0] r_rdPtr;
  logic [CNTW-1:0] r_count;
  logic [3:0]      r_starveCnt;

  logic            r_regWrite;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_datain;

  logic            w_empty;
  logic            w_ldReady;
  logic            w_ldFire;
  logic            w_push;
  logic            w_pop;
  sel_e            w_sel;
  logic [4:0]      w_selRd;
  logic [XLEN-1:0] w_selData;
  logic [31:0]     w_pendMask;

  // ld_ready comes straight from the registered count, so a pop in the same
  // cycle never feeds back into the handshake.
  assign w_empty   = (r_count == '0);
  assign w_ldReady = (r_count < CNTW'(DEPTH));
  assign w_ldFire  = io_bus.ld_valid && w_ldReady;

  // Fixed-priority source select: ALU, then FIFO head, then a load that can
  // skip the empty FIFO entirely.
  always_comb begin
    w_sel     = SEL_NONE;
    w_selRd   = '0;
    w_selData = '0;
    if (io_bus.alu_valid) begin
      w_sel     = SEL_ALU;
      w_selRd   = io_bus.alu_rd;
      w_selData = io_bus.alu_data;
    end else if (!w_empty) begin
      w_sel     = SEL_FIFO;
      w_selRd   = r_fifoRd[r_rdPtr];
      w_selData = r_fifoData[r_rdPtr];
    end else if (w_ldFire) begin
      w_sel     = SEL_BYPASS;
      w_selRd   = io_bus.ld_rd;
      w_selData = io_bus.ld_data;
    end
  end

  assign w_pop  = (w_sel == SEL_FIFO);
  assign w_push = w_ldFire && (w_sel != SEL_BYPASS);

  // FIFO storage has no reset; only the pointers/count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoRd[r_wrPtr]   <= io_bus.ld_rd;
      r_fifoData[r_wrPtr] <= io_bus.ld_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTRW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTRW'(1);
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  // Starvation counter: counts ALU wins while loads wait, saturating at the
  // limit; any drain progress or an empty FIFO restarts it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_starveCnt <= '0;
    end else if (w_pop || w_empty) begin
      r_starveCnt <= '0;
    end else if ((w_sel == SEL_ALU) && (r_starveCnt != 4'(STARVE_LIMIT))) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  // Write port register. Writes to x0 still consume their source but never
  // raise reg_write; address/data hold when nothing is selected.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_regWrite <= 1'b0;
      r_rd       <= '0;
      r_datain   <= '0;
    end else begin
      r_regWrite <= (w_sel != SEL_NONE) && (w_selRd != 5'd0);
      if (w_sel != SEL_NONE) begin
        r_rd     <= w_selRd;
        r_datain <= w_selData;
      end
    end
  end

  // Pending mask over the valid FIFO window [rdPtr, rdPtr+count). Built from
  // registered state, so an entry's bit drops on the edge that writes it.
  always_comb begin
    w_pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTRW'(PTRW'(i) - r_rdPtr)} < r_count) && (r_fifoRd[i] != 5'd0)) begin
        w_pendMask[r_fifoRd[i]] = 1'b1;
      end
    end
  end

  assign io_bus.ld_ready  = w_ldReady;
  assign io_bus.alu_hold  = (r_starveCnt == 4'(STARVE_LIMIT));
  assign io_bus.rd        = r_rd;
  assign io_bus.datain    = r_datain;
  assign io_bus.reg_write = r_regWrite;
  assign io_bus.pend_mask = w_pendMask;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Purpose : directed testbench for wb_arbiter (XLEN=32, DEPTH=2,
//           STARVE_LIMIT=4). Expected register-file writes are queued in
//           hand-computed order when stimulus is issued; a monitor pops one
//           entry for every reg_write pulse. Handshake, hold and pending-mask
//           values are compared directly against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32)) bus ();

  wb_arbiter #(
    .XLEN(32),
    .DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rstN),
    .io_bus (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wrExp_t;

  wrExp_t expQ[$];
  int     vectors     = 0;
  int     miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ld;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
    expQ.push_back({rd, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write pulse must match the next queued expectation.
  always @(negedge clk) begin
    wrExp_t e;
    if (rstN === 1'b1 && bus.reg_write === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write",
                 bus.rd, bus.datain);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb_rd", 32'(bus.rd), 32'(e.rd));
        checkOutput("wb_data", bus.datain, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    rstN = 1'b1;
    #1 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_we",    32'(bus.reg_write), 32'd0);
    checkOutput("rst_rd",    32'(bus.rd),        32'd0);
    checkOutput("rst_data",  bus.datain,         32'd0);
    checkOutput("rst_hold",  32'(bus.alu_hold),  32'd0);
    checkOutput("rst_pend",  bus.pend_mask,      32'd0);
    checkOutput("rst_ready", 32'(bus.ld_ready),  32'd1);
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // T1: ALU only, one-cycle latency
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    checkOutput("t1_we", 32'(bus.reg_write), 32'd1);
    tick();

    // T2: load bypass with empty FIFO
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
    checkOutput("t2_ready", 32'(bus.ld_ready), 32'd1);
    expectWrite(5'd7, 32'h12);
    tick();
    idle();
    checkOutput("t2_we",   32'(bus.reg_write), 32'd1);
    checkOutput("t2_pend", bus.pend_mask,      32'd0);
    tick();

    // T3: collision, ALU first, load buffered then drained
    applyStimulus(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444);
    checkOutput("t3_ready", 32'(bus.ld_ready), 32'd1);
    expectWrite(5'd3, 32'h33333333);
    expectWrite(5'd4, 32'h44444444);
    tick();
    idle();
    checkOutput("t3_pend_set", bus.pend_mask, 32'h0000_0010);
    tick();
    checkOutput("t3_pend_clr", bus.pend_mask,      32'd0);
    checkOutput("t3_we",       32'(bus.reg_write), 32'd1);
    tick();
    checkOutput("t3_quiet", 32'(bus.reg_write), 32'd0);

    // T4: ALU held, three loads offered; FIFO fills at two
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd20, 32'h200);
    checkOutput("t4_ready0", 32'(bus.ld_ready), 32'd1);
    expectWrite(5'd10, 32'hA0);
    tick();
    applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1, 5'd21, 32'h210);
    checkOutput("t4_ready1", 32'(bus.ld_ready), 32'd1);
    expectWrite(5'd11, 32'hA1);
    tick();
    applyStimulus(1'b1, 5'd12, 32'hA2, 1'b1, 5'd22, 32'h220);
    checkOutput("t4_ready2", 32'(bus.ld_ready), 32'd0);
    checkOutput("t4_pend2",  bus.pend_mask,     32'h0030_0000);
    expectWrite(5'd12, 32'hA2);
    tick();
    checkOutput("t4_hold", 32'(bus.alu_hold), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h220);
    checkOutput("t4_ready3", 32'(bus.ld_ready), 32'd0);
    expectWrite(5'd20, 32'h200);
    tick();
    checkOutput("t4_ready4", 32'(bus.ld_ready), 32'd1);
    expectWrite(5'd21, 32'h210);
    tick();
    idle();
    checkOutput("t4_pend22", bus.pend_mask, 32'h0040_0000);
    expectWrite(5'd22, 32'h220);
    tick();
    checkOutput("t4_pend_clr", bus.pend_mask, 32'd0);

    // T5: starvation, hold after four ALU wins over a waiting load
    applyStimulus(1'b1, 5'd1, 32'h501, 1'b1, 5'd9, 32'h909);
    expectWrite(5'd1, 32'h501);
    tick();
    for (int k = 2; k <= 6; k++) begin
      applyStimulus(1'b1, 5'(k), 32'h500 + 32'(k), 1'b0, 5'd0, 32'h0);
      expectWrite(5'(k), 32'h500 + 32'(k));
      tick();
      if (k == 4) checkOutput("t5_hold_early", 32'(bus.alu_hold), 32'd0);
      if (k >= 5) checkOutput("t5_hold_set",   32'(bus.alu_hold), 32'd1);
    end
    idle();
    checkOutput("t5_pend9", bus.pend_mask, 32'h0000_0200);
    expectWrite(5'd9, 32'h909);
    tick();
    checkOutput("t5_hold_clr", 32'(bus.alu_hold), 32'd0);
    checkOutput("t5_pend_clr", bus.pend_mask,     32'd0);

    // T6: x0 loads are consumed silently; reset mid-drain
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
    checkOutput("t6_ready_x0", 32'(bus.ld_ready), 32'd1);
    tick();
    checkOutput("t6_we_x0", 32'(bus.reg_write), 32'd0);
    applyStimulus(1'b1, 5'd13, 32'hD13, 1'b1, 5'd0, 32'hF00);
    expectWrite(5'd13, 32'hD13);
    tick();
    checkOutput("t6_pend_x0", bus.pend_mask, 32'd0);
    applyStimulus(1'b1, 5'd14, 32'hD14, 1'b1, 5'd15, 32'hF15);
    expectWrite(5'd14, 32'hD14);
    tick();
    idle();
    checkOutput("t6_pend15", bus.pend_mask, 32'h0000_8000);
    tick();
    checkOutput("t6_we_pop_x0", 32'(bus.reg_write), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'hF16);
    checkOutput("t6_ready16", 32'(bus.ld_ready), 32'd1);
    expectWrite(5'd15, 32'hF15);
    tick();
    idle();
    checkOutput("t6_pend16", bus.pend_mask, 32'h0001_0000);
    @(negedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("t6_rst_we",   32'(bus.reg_write), 32'd0);
    checkOutput("t6_rst_rd",   32'(bus.rd),        32'd0);
    checkOutput("t6_rst_data", bus.datain,         32'd0);
    checkOutput("t6_rst_pend", bus.pend_mask,      32'd0);
    tick();
    @(negedge clk);
    rstN = 1'b1;
    tick();
    checkOutput("t6_ready_rel", 32'(bus.ld_ready), 32'd1);
    tick();
    checkOutput("t6_discarded", 32'(bus.reg_write), 32'd0);
    applyStimulus(1'b1, 5'd17, 32'h17171717, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd17, 32'h17171717);
    tick();
    idle();
    tick();
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
